// File: rtl/shift_requant_pkg.sv
// -----------------------------------------------------------------------------
// shift_requant_pkg
// Shared widths, saturation bounds and datapath types for the shift_requant
// requantizer and its saturator.
//   IN_W     accumulator width (two's complement)
//   SH_W     shift-amount port width (unsigned)
//   OUT_W    requantized result width (two's complement)
//   SH_MAX   largest meaningful shift; larger requests are clamped to it
//   SH_IDX_W bits needed to hold a clamped shift amount
// -----------------------------------------------------------------------------
package shift_requant_pkg;

  localparam int IN_W     = 64;
  localparam int SH_W     = 8;
  localparam int OUT_W    = 8;

  localparam int SAT_MAX  = 127;
  localparam int SAT_MIN  = -128;
  localparam int SH_MAX   = IN_W - 1;
  localparam int SH_IDX_W = $clog2(IN_W);

  typedef logic signed [IN_W-1:0]  acc_t;
  typedef logic signed [OUT_W-1:0] q8_t;

endpackage

// File: rtl/shift_requant_sat_clip.sv
// -----------------------------------------------------------------------------
// sat_clip
// Combinational signed saturator from accumulator width down to int8.
// Values above SAT_MAX clip to 0x7F, values below SAT_MIN clip to 0x80, and
// anything in range passes through as its low OUT_W bits.
// Ports:
//   x  in   acc_t  signed value to clip
//   y  out  q8_t   saturated signed result
// -----------------------------------------------------------------------------
module sat_clip
  import shift_requant_pkg::*;
(
  input  acc_t x,
  output q8_t  y
);

  // NOTE: every path assigns y, so this stays pure logic and no latch is inferred.
  always_comb begin
    if (x > acc_t'(SAT_MAX)) begin
      y = q8_t'(SAT_MAX);
    end else if (x < acc_t'(SAT_MIN)) begin
      y = q8_t'(SAT_MIN);
    end else begin
      y = x[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/shift_requant.sv
// -----------------------------------------------------------------------------
// shift_requant
// Requantizer at the 3x3 convolution output. The signed accumulator is
// arithmetic-right-shifted by a per-layer amount, saturated to int8 and
// registered. Two register stages give a latency of two clocks and a
// throughput of one sample per clock. There is no handshake.
//
// Build option SHIFT_REQUANT_ROUND_EN:
//   defined   -> round half up before the shift: (TEMP + 2^(sh-1)) >>> sh
//   undefined -> truncate toward minus infinity: TEMP >>> sh
// Latency and ports do not depend on this option.
//
// Ports:
//   CLK     in   1      clock, rising edge
//   RSTN    in   1      asynchronous reset, active HIGH despite the name
//   TEMP    in   IN_W   signed accumulator, sampled every CLK
//   Shift   in   SH_W   unsigned right-shift amount, sampled with TEMP
//   Result  out  OUT_W  signed saturated result, registered
// -----------------------------------------------------------------------------
module shift_requant
  import shift_requant_pkg::*;
(
  input  logic            CLK,
  input  logic            RSTN,
  input  acc_t            TEMP,
  input  logic [SH_W-1:0] Shift,
  output q8_t             Result
);

  logic [SH_IDX_W-1:0] sh;
  acc_t                shifted;
  acc_t                s1;
  q8_t                 clipped;

  // A shift of IN_W-1 already collapses any value to 0 or -1, so larger
  // requests are clamped to it instead of relying on out-of-range shift rules.
  always_comb begin
    if (Shift > SH_W'(SH_MAX)) begin
      sh = SH_IDX_W'(SH_MAX);
    end else begin
      sh = Shift[SH_IDX_W-1:0];
    end
  end

`ifdef SHIFT_REQUANT_ROUND_EN
  // The rounding add is carried out one bit wider than the accumulator so
  // the most positive accumulator plus the bias cannot wrap negative. After
  // a shift of at least one bit the result fits back in IN_W bits.
  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] bias;

  always_comb begin
    ext  = {TEMP[IN_W-1], TEMP};
    bias = '0;
    if (sh != '0) begin
      bias = {{IN_W{1'b0}}, 1'b1} << (sh - 1'b1);
    end
    shifted = acc_t'((ext + bias) >>> sh);
  end
`else
  always_comb begin
    shifted = TEMP >>> sh;
  end
`endif

  // NOTE: registers use non-blocking assignments so every stage samples the
  // previous stage's value from before the clock edge.
  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      s1 <= '0;
    end else begin
      s1 <= shifted;
    end
  end

  sat_clip u_sat_clip (
    .x (s1),
    .y (clipped)
  );

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      Result <= '0;
    end else begin
      Result <= clipped;
    end
  end

endmodule

// File: tb/tb_shift_requant.sv
// -----------------------------------------------------------------------------
// tb_shift_requant
// Directed self-checking bench for shift_requant. Each step drives one
// TEMP/Shift pair together with its hand-computed result. One edge later,
// that result becomes the value expected on Result. Vectors whose answer
// depends on the rounding option are selected with SHIFT_REQUANT_ROUND_EN.
// -----------------------------------------------------------------------------
module tb_shift_requant;
  import shift_requant_pkg::*;

  logic            CLK = 1'b0;
  logic            RSTN;
  acc_t            TEMP;
  logic [SH_W-1:0] Shift;
  q8_t             Result;

  int errors = 0;
  int checks = 0;

  logic [7:0] prev_exp;
  string      prev_tag;
  bit         prev_v = 1'b0;

  shift_requant dut (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .TEMP   (TEMP),
    .Shift  (Shift),
    .Result (Result)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Drive one sample and clock it in. Result then holds the sample that was
  // captured one edge earlier, so it is compared with the previous expectation.
  task automatic step(input acc_t t, input logic [7:0] s, input logic [7:0] e, input string tag);
    TEMP  = t;
    Shift = s;
    @(posedge CLK);
    #1;
    if (prev_v) check(prev_tag, Result, prev_exp);
    prev_exp = e;
    prev_tag = tag;
    prev_v   = 1'b1;
  endtask

  initial begin
    // Reset state
    RSTN  = 1'b1;
    TEMP  = 64'sh7F;
    Shift = 8'd0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_hold", Result, 8'h00);

    // Release: the result must still read 0 after the first edge and 0x7F after the second.
    RSTN = 1'b0;
    @(posedge CLK);
    #1;
    check("rel_edge1", Result, 8'h00);
    @(posedge CLK);
    #1;
    check("rel_edge2", Result, 8'h7F);

    // Ramp with Shift = 3
    for (int i = 0; i < 256; i++) begin
`ifdef SHIFT_REQUANT_ROUND_EN
      step(acc_t'(i), 8'd3, 8'((i + 4) >> 3), $sformatf("ramp_%0d", i));
`else
      step(acc_t'(i), 8'd3, 8'(i >> 3), $sformatf("ramp_%0d", i));
`endif
    end

    // Saturation with Shift = 0
    step(64'sh80,  8'd0, 8'h7F, "sat_128");
    step(-64'sd129, 8'd0, 8'h80, "sat_m129");
    step(64'sh7F,  8'd0, 8'h7F, "sat_127");
    step(-64'sd128, 8'd0, 8'h80, "sat_m128");
    step(64'sh8000_0000_0000_0000, 8'd0, 8'h80, "sat_accmin");
    step(64'sh7FFF_FFFF_FFFF_FFFF, 8'd0, 8'h7F, "sat_accmax");

    // Negative values, large shifts, and vectors sensitive to rounding
`ifdef SHIFT_REQUANT_ROUND_EN
    step(-64'sd9,   8'd3,   8'hFF, "neg_m9_sh3");
    step(-64'sd1,   8'd200, 8'h00, "neg_m1_sh200");
    step(64'sd5,    8'd200, 8'h00, "pos_5_sh200");
    step(-64'sd100, 8'd64,  8'h00, "neg_m100_sh64");
    step(64'sh7FFF_FFFF_FFFF_FFFF, 8'd255, 8'h01, "max_sh255");
    step(64'sd12,   8'd3,   8'h02, "rnd_12");
    step(64'sd11,   8'd3,   8'h01, "rnd_11");
    step(-64'sd12,  8'd3,   8'hFF, "rnd_m12");
    step(64'sh7FFF_FFFF_FFFF_FFFF, 8'd3, 8'h7F, "rnd_max");
`else
    step(-64'sd9,   8'd3,   8'hFE, "neg_m9_sh3");
    step(-64'sd1,   8'd200, 8'hFF, "neg_m1_sh200");
    step(64'sd5,    8'd200, 8'h00, "pos_5_sh200");
    step(-64'sd100, 8'd64,  8'hFF, "neg_m100_sh64");
    step(64'sh7FFF_FFFF_FFFF_FFFF, 8'd255, 8'h00, "max_sh255");
    step(64'sd12,   8'd3,   8'h01, "trn_12");
    step(64'sd11,   8'd3,   8'h01, "trn_11");
    step(-64'sd12,  8'd3,   8'hFE, "trn_m12");
    step(64'sh7FFF_FFFF_FFFF_FFFF, 8'd3, 8'h7F, "trn_max");
`endif

    // Back-to-back samples with a different shift on each edge
    step(64'sh400, 8'd3,  8'h7F, "b2b_sh3");
    step(64'sh400, 8'd4,  8'h40, "b2b_sh4");
    step(64'sh400, 8'd10, 8'h01, "b2b_sh10");

    // Mid-stream reset: asserting reset clears Result immediately, and the
    // sample that was still in stage 1 (0x20) must not appear afterwards.
    step(64'sh10, 8'd0, 8'h10, "pre_rst_a");
    step(64'sh20, 8'd0, 8'h20, "pre_rst_b");
    #2;
    RSTN = 1'b1;
    #1;
    check("rst_async", Result, 8'h00);
    prev_v = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_in_edge", Result, 8'h00);
    RSTN = 1'b0;
    step(64'sh33, 8'd0, 8'h33, "post_rst");
    check("rst_discard", Result, 8'h00);
    step(64'sh2A, 8'd1, 8'h15, "post_rst_b");
    step(64'sh0,  8'd0, 8'h00, "flush");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Upper bound on simulation time, in case the stimulus never completes
  initial begin
    #100000;
    $display("FAIL timeout: stimulus did not complete");
    $fatal(1, "timeout");
  end

endmodule
